// File: rtl/snes_pad_responder.sv
// SNES controller responder: answers host latch/clock strobes with the 16-bit
// active-low button stream. Host strobes are asynchronous and synchronized here.
module snes_pad_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        snes_clk_in,
    input  logic        data_latch_in,
    input  logic [11:0] buttons,
    output logic        serial_data,
    output logic        frame_done,
    output logic [4:0]  bit_index
);

    typedef enum logic [1:0] {IDLE, LATCHED, SHIFT, DONE} state_t;

    logic [SYNC_STAGES-1:0] clk_sync, latch_sync;
    logic                   clk_hist, latch_hist;
    logic                   clk_s, latch_s;
    logic                   clk_rise_q, latch_rise_q, latch_fall_q;

    state_t      state, state_n;
    logic [15:0] shreg, shreg_n;
    logic [4:0]  idx_n;
    logic        sd_n, fd_n;

    assign clk_s   = clk_sync[SYNC_STAGES-1];
    assign latch_s = latch_sync[SYNC_STAGES-1];

    // Edge pulses are registered so the FSM sees a clean one-cycle event and
    // the total input-to-output latency is SYNC_STAGES + 2.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync     <= '1;
            latch_sync   <= '0;
            clk_hist     <= 1'b1;
            latch_hist   <= 1'b0;
            clk_rise_q   <= 1'b0;
            latch_rise_q <= 1'b0;
            latch_fall_q <= 1'b0;
        end else begin
            clk_sync     <= {clk_sync[SYNC_STAGES-2:0], snes_clk_in};
            latch_sync   <= {latch_sync[SYNC_STAGES-2:0], data_latch_in};
            clk_hist     <= clk_s;
            latch_hist   <= latch_s;
            clk_rise_q   <= clk_s & ~clk_hist;
            latch_rise_q <= latch_s & ~latch_hist;
            latch_fall_q <= ~latch_s & latch_hist;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= 16'hFFFF;
            bit_index   <= 5'd0;
            serial_data <= 1'b1;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            shreg       <= shreg_n;
            bit_index   <= idx_n;
            serial_data <= sd_n;
            frame_done  <= fd_n;
        end
    end

    always_comb begin
        state_n = state;
        shreg_n = shreg;
        idx_n   = bit_index;
        sd_n    = serial_data;
        fd_n    = 1'b0;
        // A latch edge restarts the frame from any state and beats a clock edge.
        if (latch_rise_q) begin
            shreg_n = {4'b1111, ~buttons};
            idx_n   = 5'd0;
            sd_n    = ~buttons[0];
            state_n = LATCHED;
        end else begin
            case (state)
                IDLE: begin
                    sd_n  = 1'b1;
                    idx_n = 5'd0;
                end
                LATCHED: begin
                    if (latch_fall_q) state_n = SHIFT;
                end
                SHIFT: begin
                    if (clk_rise_q) begin
                        if (bit_index == 5'd15) begin
                            idx_n   = 5'd16;
                            sd_n    = 1'b0;
                            fd_n    = 1'b1;
                            state_n = DONE;
                        end else begin
                            shreg_n = {1'b1, shreg[15:1]};
                            sd_n    = shreg[1];
                            idx_n   = bit_index + 5'd1;
                        end
                    end
                end
                DONE: begin
                    sd_n  = 1'b0;
                    idx_n = 5'd16;
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snes_pad_responder.sv
// Directed + randomized bench for snes_pad_responder; expected stream is built
// from the button word directly (bit k = ~buttons[k] for k<12, else 1).
module tb_snes_pad_responder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        snes_clk_in = 1'b1;
    logic        data_latch_in = 1'b0;
    logic [11:0] buttons = '0;
    logic        serial_data, frame_done;
    logic [4:0]  bit_index;

    int total = 0;
    int bad = 0;
    int fd_cnt = 0;

    snes_pad_responder #(.SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .snes_clk_in  (snes_clk_in),
        .data_latch_in(data_latch_in),
        .buttons      (buttons),
        .serial_data  (serial_data),
        .frame_done   (frame_done),
        .bit_index    (bit_index)
    );

    always #10 clk = ~clk;

    always @(posedge clk) if (frame_done === 1'b1) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_bit(input logic [11:0] b, input int k);
        return (k < 12) ? ~b[k] : 1'b1;
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch(input logic [11:0] b);
        buttons = b;
        data_latch_in = 1'b1;
        cyc(12);
        data_latch_in = 1'b0;
        cyc(12);
    endtask

    task automatic pulse();
        snes_clk_in = 1'b0;
        cyc(8);
        snes_clk_in = 1'b1;
        cyc(8);
    endtask

    // Checks bit k of a frame already latched with b (k=16 means DONE).
    task automatic chk_bit(input string tag, input logic [11:0] b, input int k);
        if (k < 16) begin
            chk({tag, "_sd"}, serial_data, exp_bit(b, k));
            chk({tag, "_idx"}, bit_index, k);
        end else begin
            chk({tag, "_done_sd"}, serial_data, 0);
            chk({tag, "_done_idx"}, bit_index, 16);
        end
    endtask

    task automatic frame(input string tag, input logic [11:0] b, input int np);
        int fd0;
        latch(b);
        fd0 = fd_cnt;
        chk_bit(tag, b, 0);
        for (int k = 1; k <= np; k++) begin
            pulse();
            buttons = 12'($urandom);
            chk_bit(tag, b, (k > 16) ? 16 : k);
        end
        chk({tag, "_fd"}, fd_cnt - fd0, (np >= 16) ? 1 : 0);
    endtask

    initial begin
        int fd0;
        logic [11:0] b;
        cyc(3);
        chk("rst_sd", serial_data, 1);
        chk("rst_idx", bit_index, 0);
        chk("rst_fd", frame_done, 0);
        reset = 1'b0;
        cyc(2);

        // Clock pulses in IDLE are ignored.
        for (int i = 0; i < 3; i++) begin
            pulse();
            chk("idle_sd", serial_data, 1);
            chk("idle_idx", bit_index, 0);
        end
        chk("idle_fd", fd_cnt, 0);

        frame("b_only", 12'h001, 16);
        frame("a5a", 12'hA5A, 16);
        frame("over20", 12'h3C7, 20);

        // Reset mid-frame.
        latch(12'h0F0);
        for (int k = 0; k < 5; k++) pulse();
        fd0 = fd_cnt;
        reset = 1'b1;
        cyc(1);
        chk("midrst_sd", serial_data, 1);
        chk("midrst_idx", bit_index, 0);
        reset = 1'b0;
        cyc(2);
        pulse();
        chk("postrst_idle_sd", serial_data, 1);
        chk("midrst_fd", fd_cnt - fd0, 0);
        frame("after_rst", 12'h0F0, 16);

        // Relatch after 8 pulses aborts without frame_done.
        latch(12'hFFF);
        for (int k = 0; k < 8; k++) pulse();
        fd0 = fd_cnt;
        frame("relatch", 12'h000, 16);
        chk("relatch_abort_fd", fd_cnt - fd0, 1);

        // Latency: raw rise at cycle N shows on serial_data after the 4th edge.
        latch(12'h001);
        snes_clk_in = 1'b0;
        cyc(8);
        snes_clk_in = 1'b1;
        for (int e = 1; e <= 4; e++) begin
            cyc(1);
            buttons = 12'($urandom);
            chk($sformatf("lat_e%0d", e), serial_data, (e < 4) ? 0 : 1);
        end
        cyc(6);
        for (int k = 2; k <= 16; k++) begin
            pulse();
            chk_bit("lat_rest", 12'h001, k);
        end

        // Latch and clock rising together mid-shift: latch wins.
        latch(12'h555);
        pulse();
        pulse();
        fd0 = fd_cnt;
        snes_clk_in = 1'b0;
        cyc(8);
        b = 12'h2B6;
        buttons = b;
        snes_clk_in = 1'b1;
        data_latch_in = 1'b1;
        cyc(12);
        data_latch_in = 1'b0;
        cyc(12);
        chk_bit("both", b, 0);
        for (int k = 1; k <= 16; k++) begin
            pulse();
            chk_bit("both", b, k);
        end
        chk("both_fd", fd_cnt - fd0, 1);

        // Random frames.
        for (int r = 0; r < 4; r++)
            frame("rnd", 12'($urandom), $urandom_range(16, 20));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
